// File: rtl/sprite_pkg.sv
// Shared constants, state type and ROM address helper for the sprite line fetcher.
package sprite_pkg;

  localparam int SPRITE_W = 21;
  localparam int SPRITE_H = 41;
  localparam int H_ACTIVE = 640;
  localparam logic [23:0] TRANSPARENT_KEY = 24'h800080;

  typedef enum logic {IDLE, FETCH} fetch_state_t;

  // Row-major ROM address; largest value is 40*21+20 = 860.
  function automatic logic [9:0] rom_addr(input logic [5:0] row, input logic [4:0] col);
    return 10'(row) * 10'(SPRITE_W) + 10'(col);
  endfunction

endpackage

// File: rtl/sprite_line_buffer.sv
// Ping-pong sprite line storage: one write port, one combinational read port,
// and a per-buffer valid bit plus latched left column.
module sprite_line_buffer
  import sprite_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        start_sel,
  input  logic [9:0]  start_x,
  input  logic        we,
  input  logic        wr_sel,
  input  logic [4:0]  wr_idx,
  input  logic [23:0] wr_data,
  input  logic        set_valid,
  input  logic        rd_sel,
  input  logic [4:0]  rd_idx,
  output logic [23:0] rd_data,
  output logic        rd_valid,
  output logic [9:0]  rd_x
);

  logic [23:0] mem [2][SPRITE_W];
  logic [1:0]  valid;
  logic [9:0]  buf_x [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= '0;
      buf_x[0] <= '0;
      buf_x[1] <= '0;
    end else if (start) begin
      valid[start_sel] <= 1'b0;
      buf_x[start_sel] <= start_x;
    end else if (set_valid) begin
      valid[wr_sel] <= 1'b1;
    end
  end

  // NOTE: the pixel array is deliberately not reset; the valid bits alone gate
  // its use, and an unreset array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_sel][wr_idx] <= wr_data;
  end

  assign rd_data  = mem[rd_sel][rd_idx];
  assign rd_valid = valid[rd_sel];
  assign rd_x     = buf_x[rd_sel];

endmodule

// File: rtl/sprite_line_fetcher.sv
// Prefetches one sprite row from ROM during the previous scanline and replays
// it against DrawX as a registered opaque/transparent pixel stream.
module sprite_line_fetcher
  import sprite_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        line_start,
  input  logic [9:0]  next_y,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        sprite_flip,
  input  logic [9:0]  DrawX,
  output logic [9:0]  read_address,
  input  logic [23:0] rom_color,
  output logic [23:0] pixel_color,
  output logic        pixel_on,
  output logic        busy
);

  fetch_state_t state;
  logic        wr;
  logic [5:0]  row_q;
  logic [4:0]  col_q;
  logic        flip_q;

  logic [10:0] row_s;
  logic        row_hit;
  logic        last_col;
  logic        buf_we;
  logic        buf_set_valid;
  logic [4:0]  wr_idx;

  logic [10:0] dx;
  logic        in_range;
  logic [4:0]  rd_idx;
  logic [23:0] rd_data;
  logic        rd_valid;
  logic [9:0]  rd_x;

  assign row_s    = {1'b0, next_y} - {1'b0, sprite_y};
  assign row_hit  = !row_s[10] && (row_s < 11'(SPRITE_H));
  assign last_col = (col_q == 5'(SPRITE_W - 1));

  // A line_start during FETCH aborts: the last write and its valid are suppressed.
  assign buf_we        = (state == FETCH) && !line_start;
  assign buf_set_valid = buf_we && last_col;
  assign wr_idx        = flip_q ? 5'(SPRITE_W - 1) - col_q : col_q;
  assign busy          = (state == FETCH);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      wr           <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      flip_q       <= 1'b0;
      read_address <= '0;
    end else if (line_start) begin
      wr     <= !wr;
      row_q  <= row_s[5:0];
      col_q  <= '0;
      flip_q <= sprite_flip;
      if (row_hit) begin
        state        <= FETCH;
        read_address <= rom_addr(row_s[5:0], 5'd0);
      end else begin
        state <= IDLE;
      end
    end else begin
      case (state)
        FETCH: begin
          if (last_col) begin
            state <= IDLE;
          end else begin
            col_q        <= col_q + 5'd1;
            read_address <= rom_addr(row_q, col_q + 5'd1);
          end
        end
        default: ;
      endcase
    end
  end

  sprite_line_buffer u_buf (
    .clk       (Clk),
    .rst       (Reset),
    .start     (line_start),
    .start_sel (!wr),
    .start_x   (sprite_x),
    .we        (buf_we),
    .wr_sel    (wr),
    .wr_idx    (wr_idx),
    .wr_data   (rom_color),
    .set_valid (buf_set_valid),
    .rd_sel    (!wr),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_x      (rd_x)
  );

  // Columns past the visible area are never presented, so no wrap-around.
  assign dx       = {1'b0, DrawX} - {1'b0, rd_x};
  assign in_range = rd_valid && !dx[10] && (dx < 11'(SPRITE_W)) && (DrawX < 10'(H_ACTIVE));
  assign rd_idx   = in_range ? dx[4:0] : 5'd0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pixel_on    <= 1'b0;
      pixel_color <= '0;
    end else begin
      pixel_on    <= in_range && (rd_data != TRANSPARENT_KEY);
      pixel_color <= in_range ? rd_data : 24'h0;
    end
  end

endmodule

// File: doc/sprite_line_fetcher.md
# sprite_line_fetcher

Reader side of the sprite ROMs: prefetches one row of a 21×41 palette-decoded sprite (e.g. big Mario) into a ping-pong line buffer during the previous scanline, then replays it against DrawX as an opaque/transparent pixel stream for the color mapper. Drives the ROM's 10-bit `read_address` and consumes its combinational 24-bit `output_color`. Sits between the VGA controller and the color mapper, one instance per on-screen sprite.

## Interface
- `SPRITE_W`, 21, sprite width in pixels
- `SPRITE_H`, 41, sprite height in rows
- `Clk`  in  1  system clock
- `Reset`  in  1  asynchronous, active-high
- `line_start`  in  1  single-cycle pulse at start of each scanline
- `next_y`  in  10  scanline to prefetch, sampled on `line_start`
- `sprite_x`  in  10  sprite left column, sampled on `line_start`
- `sprite_y`  in  10  sprite top row, sampled on `line_start`
- `sprite_flip`  in  1  1 = mirror horizontally (facing left), sampled on `line_start`
- `DrawX`  in  10  current pixel column
- `read_address`  out  10  ROM address
- `rom_color`  in  24  ROM data, combinational from `read_address`
- `pixel_color`  out  24  registered sprite color
- `pixel_on`  out  1  registered, 1 = opaque sprite pixel at previous DrawX
- `busy`  out  1  fetch in progress

One clock; reset asynchronous, active-high.

## Operation
- Two buffers, each SPRITE_W × 24 bits plus `valid` bit and latched `buf_x`. Pointer `wr` selects fetch buffer; `!wr` is display buffer.
- On `line_start`: toggle `wr` (just-fetched buffer becomes display); compute `row = next_y - sprite_y` as 11-bit signed; latch `sprite_x`, `sprite_flip` into new fetch buffer context; clear new fetch buffer `valid`.
  - If 0 ≤ row < SPRITE_H: enter FETCH, `col = 0`.
  - Else stay IDLE; buffer stays invalid.
- FETCH: `read_address = row*SPRITE_W + col` (max 860, fits 10 bits). Each cycle write `rom_color` to index `sprite_flip ? SPRITE_W-1-col : col`. At `col == SPRITE_W-1`: write, set `valid`, go IDLE.
- IDLE: `read_address` holds last value; no writes.
- Display, every cycle: `dx = DrawX - buf_x` (11-bit signed). `pixel_on <= valid[!wr] && 0 ≤ dx < SPRITE_W && buf[!wr][dx] != 24'h800080`; `pixel_color <= in-range ? buf[!wr][dx] : 0`.
- States: IDLE, FETCH. `busy = (state == FETCH)`.

## Timing
- Reset: state IDLE, `wr` 0, both `valid` 0, `read_address` 0, `pixel_color` 0, `pixel_on` 0, `busy` 0. Buffer contents undefined.
- Fetch: first address in cycle after `line_start`; SPRITE_W consecutive cycles; `valid` set in cycle after last write.
- Display latency: 1 cycle from DrawX to `pixel_on`/`pixel_color`.
- `line_start` during FETCH: abort, fetch buffer left invalid, swap and restart per new sample in same cycle. Aborted row never displayed.
- `line_start` while `Reset` high: ignored.
- Reset mid-fetch: immediate IDLE; no sprite pixels on following line.
- Sprite partially off right edge: columns with DrawX ≥ 640 never presented; no wrap. `sprite_x` > 639 yields no visible pixels.
- Sprite params change mid-line: no effect until next `line_start`.

## Structure
- Package `sprite_pkg`: `SPRITE_W`, `SPRITE_H`, `TRANSPARENT_KEY = 24'h800080`, `fetch_state_t` enum {IDLE, FETCH}.
- Sub-module `sprite_line_buffer`: ping-pong storage, one write port (buf sel, index, data), one read port (buf sel, index), per-buffer `valid` and `buf_x`.

## Test plan
- sprite_y=100, next_y=100, flip=0, line_start → `read_address` 0,1,…,20 on 21 consecutive cycles, `busy` high exactly 21 cycles.
- Same row, then second line_start, sprite_x=200, DrawX=200+k → one cycle later `pixel_color` = ROM[k] and `pixel_on`=1 when ROM[k] ≠ 800080.
- flip=1, next_y=101 → at display, DrawX=sprite_x shows ROM[21+20]; DrawX=sprite_x+20 shows ROM[21].
- next_y=99 and next_y=141 (sprite_y=100) → no fetch, `busy` 0, `pixel_on` 0 for entire following line.
- Pixel equal to 24'h800080 → `pixel_on` 0; DrawX = sprite_x−1 and sprite_x+21 → `pixel_on` 0.
- line_start at 10th fetch cycle, new next_y=sprite_y+5 → restart at address 105; following line shows no pixels; Reset mid-fetch → all outputs 0 within same cycle edge.
